avalon_key_led_responder: RTL

Avalon-MM responder peripheral for the lab7 NIOS II switch-accumulator system. The processor is the bus initiator; this block answers its reads and writes. It presents synchronized switch inputs, a writable LED register, and debounced, edge-captured ACCUMULATE/RESET keys with a maskable interrupt. It replaces the separate generic PIO cores with one register-mapped slave on the system interconnect.

---
 rtl/lab7_pio_pkg.sv | 22 ++
 rtl/key_debouncer.sv | 54 +++++
 rtl/avalon_key_led_responder.sv | 103 ++++++++++
 3 files changed

// File: rtl/lab7_pio_pkg.sv
// Shared definitions for the lab7 switch/LED/key responder: register map,
// key bit positions and the default debounce interval.
package lab7_pio_pkg;

    localparam logic [1:0] ADDR_SW   = 2'd0;
    localparam logic [1:0] ADDR_LED  = 2'd1;
    localparam logic [1:0] ADDR_KEY  = 2'd2;
    localparam logic [1:0] ADDR_MASK = 2'd3;

    localparam int KEY_ACC = 0;
    localparam int KEY_RST = 1;

    // 10 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // KEY register layout: edge-capture bits in [1:0], pressed levels in [3:2]
    function automatic logic [31:0] key_reg_word(input logic [1:0] edge_bits,
                                                 input logic [1:0] level_bits);
        return {28'b0, level_bits, edge_bits};
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes one active-low key and accepts a new level only after it has
// been stable for DEBOUNCE_CYCLES consecutive cycles; flags each new press.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = lab7_pio_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        meta_d   = key_n;
        sync_d   = meta_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b1;
            sync_q   <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pressed     = ~stable_q;
    // Fires on the edge that accepts a press, so the captured edge bit and
    // the debounced level update together.
    assign press_pulse = stable_q & ~stable_d;

endmodule

// File: rtl/avalon_key_led_responder.sv
// Avalon-MM responder exposing synchronized switches, an LED register and
// debounced edge-captured keys with a maskable level interrupt.
module avalon_key_led_responder
    import lab7_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_irq,
    input  logic [7:0]  sw,
    input  logic        key_accumulate_n,
    input  logic        key_reset_n,
    output logic [7:0]  led
);

    logic [7:0]  sw_meta_q, sw_meta_d;
    logic [7:0]  sw_sync_q, sw_sync_d;
    logic [7:0]  led_q, led_d;
    logic [1:0]  edge_q, edge_d;
    logic [1:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_word;
    logic [1:0]  key_pressed;
    logic [1:0]  key_pulse;
    logic        unused_wdata;

    assign unused_wdata = ^avs_writedata[31:8];

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_acc (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .key_n       (key_accumulate_n),
        .pressed     (key_pressed[KEY_ACC]),
        .press_pulse (key_pulse[KEY_ACC])
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rst (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .key_n       (key_reset_n),
        .pressed     (key_pressed[KEY_RST]),
        .press_pulse (key_pulse[KEY_RST])
    );

    always_comb begin
        rd_word = '0;
        case (avs_address)
            ADDR_SW:   rd_word = {24'b0, sw_sync_q};
            ADDR_LED:  rd_word = {24'b0, led_q};
            ADDR_KEY:  rd_word = key_reg_word(edge_q, key_pressed);
            ADDR_MASK: rd_word = {30'b0, mask_q};
            default:   rd_word = '0;
        endcase
    end

    always_comb begin
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
        led_d     = led_q;
        mask_d    = mask_q;
        edge_d    = edge_q;
        rdata_d   = avs_read ? rd_word : rdata_q;
        if (avs_write) begin
            case (avs_address)
                ADDR_LED:  led_d  = avs_writedata[7:0];
                ADDR_KEY:  edge_d = edge_q & ~avs_writedata[1:0];
                ADDR_MASK: mask_d = avs_writedata[1:0];
                default:   ;
            endcase
        end
        // A press landing on the same edge as a clear must not be lost.
        edge_d = edge_d | key_pulse;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            led_q     <= '0;
            edge_q    <= '0;
            mask_q    <= '0;
            rdata_q   <= '0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            led_q     <= led_d;
            edge_q    <= edge_d;
            mask_q    <= mask_d;
            rdata_q   <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign avs_irq      = |(edge_q & mask_q);
    assign led          = led_q;

endmodule
